// File: rtl/led_pattern_ctrl.sv
// LED pattern generator: drives led1..led4 from a loadable display mode,
// animated by an internal prescaler. Every output comes straight from a
// flop, so no input reaches the LEDs or step_tick without passing a clock edge.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   M_OFF   | all LEDs dark; prescaler still runs and step_tick pulses
//   M_ON    | all LEDs lit; prescaler still runs and step_tick pulses
//   M_FLOW  | one LED lit, rotating one place per step in flow_dir order
//   M_BLINK | all four LEDs toggle together on each step

module led_pattern_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    localparam int CNT_W   = $clog2(TICK_DIV)
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] mode_sel,
    input  logic       mode_load,
    input  logic       flow_dir,
    input  logic       pause,
    output logic       step_tick,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4
);

    typedef enum logic [1:0] {
        M_OFF   = 2'b00,
        M_ON    = 2'b01,
        M_FLOW  = 2'b10,
        M_BLINK = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    mode_t            mode, mode_nxt;
    logic [3:0]       pattern, pattern_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tick_nxt;

    // State, pattern, prescaler and tick flops; reset takes priority over everything.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode      <= M_OFF;
            pattern   <= 4'b0000;
            cnt       <= '0;
            step_tick <= 1'b0;
        end else begin
            mode      <= mode_nxt;
            pattern   <= pattern_nxt;
            cnt       <= cnt_nxt;
            step_tick <= tick_nxt;
        end
    end

    // Next-state logic: a load beats a terminal count, and pause freezes only the animation.
    always_comb begin
        mode_nxt    = mode;
        pattern_nxt = pattern;
        cnt_nxt     = cnt;
        tick_nxt    = 1'b0;
        if (mode_load) begin
            mode_nxt = mode_t'(mode_sel);
            cnt_nxt  = '0;
            case (mode_t'(mode_sel))
                M_OFF:   pattern_nxt = 4'b0000;
                M_ON:    pattern_nxt = 4'b1111;
                M_FLOW:  pattern_nxt = flow_dir ? 4'b1000 : 4'b0001;
                M_BLINK: pattern_nxt = 4'b1111;
                default: pattern_nxt = 4'b0000;
            endcase
        end else if (!pause) begin
            if (cnt == CNT_MAX) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                case (mode)
                    // Rotating the current pattern keeps it one-hot across direction changes.
                    M_FLOW:  pattern_nxt = flow_dir ? {pattern[0], pattern[3:1]}
                                                    : {pattern[2:0], pattern[3]};
                    M_BLINK: pattern_nxt = ~pattern;
                    default: pattern_nxt = pattern;
                endcase
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Pattern bit i drives LED i+1.
    assign led1 = pattern[0];
    assign led2 = pattern[1];
    assign led3 = pattern[2];
    assign led4 = pattern[3];

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a four-cycle animation step.
module tb_led_pattern_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [1:0] mode_sel = 2'b00;
    logic       mode_load = 1'b0;
    logic       flow_dir = 1'b0;
    logic       pause = 1'b0;
    logic       step_tick;
    logic       led1, led2, led3, led4;
    logic [3:0] leds;

    int checks = 0;
    int errors = 0;

    led_pattern_ctrl #(.TICK_DIV(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .mode_sel  (mode_sel),
        .mode_load (mode_load),
        .flow_dir  (flow_dir),
        .pause     (pause),
        .step_tick (step_tick),
        .led1      (led1),
        .led2      (led2),
        .led3      (led3),
        .led4      (led4)
    );

    assign leds = {led4, led3, led2, led1};

    always #5 sys_clk = ~sys_clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic clk1();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Three quiet cycles holding cur, then the step edge showing nxt with a tick.
    task automatic step(input string tag, input logic [3:0] cur, input logic [3:0] nxt);
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk({tag, "_quiet_tick"}, {3'b000, step_tick}, 4'b0000);
            chk({tag, "_quiet_leds"}, leds, cur);
        end
        clk1();
        chk({tag, "_tick"}, {3'b000, step_tick}, 4'b0001);
        chk({tag, "_leds"}, leds, nxt);
    endtask

    task automatic load(input logic [1:0] m, input logic dir);
        mode_sel  = m;
        flow_dir  = dir;
        mode_load = 1'b1;
        clk1();
        mode_load = 1'b0;
    endtask

    initial begin
        // 1: reset, then OFF held (paused so no tick can appear) for 20 cycles
        pause = 1'b1;
        clk1();
        clk1();
        chk("rst_leds", leds, 4'b0000);
        chk("rst_tick", {3'b000, step_tick}, 4'b0000);
        sys_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk1();
            chk("off_leds", leds, 4'b0000);
            chk("off_tick", {3'b000, step_tick}, 4'b0000);
        end
        // OFF still ticks once running, prescaler starting from 0
        pause = 1'b0;
        step("off_run", 4'b0000, 4'b0000);

        // 2: FLOW direction 0 with wrap, then reverse after 0100
        load(2'b10, 1'b0);
        chk("flow_load_leds", leds, 4'b0001);
        chk("flow_load_tick", {3'b000, step_tick}, 4'b0000);
        step("flow_s1", 4'b0001, 4'b0010);
        step("flow_s2", 4'b0010, 4'b0100);
        step("flow_s3", 4'b0100, 4'b1000);
        step("flow_wrap", 4'b1000, 4'b0001);
        step("flow_s5", 4'b0001, 4'b0010);
        step("flow_s6", 4'b0010, 4'b0100);
        flow_dir = 1'b1;
        step("flow_rev1", 4'b0100, 4'b0010);
        step("flow_rev2", 4'b0010, 4'b0001);
        step("flow_rev_wrap", 4'b0001, 4'b1000);

        // 4: pause in FLOW at 0010 with prescaler at 2
        flow_dir = 1'b0;
        step("pz_a", 4'b1000, 4'b0001);
        step("pz_b", 4'b0001, 4'b0010);
        clk1();
        clk1();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk1();
            chk("pause_tick", {3'b000, step_tick}, 4'b0000);
            chk("pause_leds", leds, 4'b0010);
        end
        pause = 1'b0;
        clk1();
        chk("unpause_c1_tick", {3'b000, step_tick}, 4'b0000);
        chk("unpause_c1_leds", leds, 4'b0010);
        clk1();
        chk("unpause_c2_tick", {3'b000, step_tick}, 4'b0001);
        chk("unpause_c2_leds", leds, 4'b0100);

        // 5: load ON on the terminal-count cycle
        clk1();
        clk1();
        clk1();
        load(2'b01, 1'b0);
        chk("coll_leds", leds, 4'b1111);
        chk("coll_tick", {3'b000, step_tick}, 4'b0000);
        step("on_hold", 4'b1111, 4'b1111);

        // 3: BLINK toggling
        load(2'b11, 1'b0);
        chk("blink_load", leds, 4'b1111);
        step("blink_1", 4'b1111, 4'b0000);
        step("blink_2", 4'b0000, 4'b1111);
        step("blink_3", 4'b1111, 4'b0000);

        // load during pause: new pattern shown, stays frozen, prescaler cleared
        pause = 1'b1;
        clk1();
        load(2'b10, 1'b1);
        chk("pload_leds", leds, 4'b1000);
        for (int i = 0; i < 6; i++) begin
            clk1();
            chk("pload_frz_tick", {3'b000, step_tick}, 4'b0000);
            chk("pload_frz_leds", leds, 4'b1000);
        end
        pause = 1'b0;
        step("pload_run", 4'b1000, 4'b0100);

        // 6: reset mid-FLOW at 0100, with a competing load that must lose
        load(2'b10, 1'b0);
        step("r6_s1", 4'b0001, 4'b0010);
        step("r6_s2", 4'b0010, 4'b0100);
        clk1();
        sys_rst   = 1'b1;
        mode_sel  = 2'b01;
        mode_load = 1'b1;
        clk1();
        chk("midrst_leds", leds, 4'b0000);
        chk("midrst_tick", {3'b000, step_tick}, 4'b0000);
        sys_rst   = 1'b0;
        mode_load = 1'b0;
        step("post_rst_off", 4'b0000, 4'b0000);
        step("post_rst_off2", 4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
